// File: rtl/bus_arbiter_per_if.sv
// Peripheral bus arbiter signal bundle: three master ports, the switch-side port and the grant vector.
interface bus_arbiter_per_if;
  logic        m0_stb_i, m1_stb_i, m2_stb_i;
  logic        m0_we_i,  m1_we_i,  m2_we_i;
  logic [31:0] m0_adr_i, m1_adr_i, m2_adr_i;
  logic [31:0] m0_dat_i, m1_dat_i, m2_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i, m2_sel_i;
  logic [31:0] m0_dat_o, m1_dat_o, m2_dat_o;
  logic        m0_ack_o, m1_ack_o, m2_ack_o;
  logic        m0_err_o, m1_err_o, m2_err_o;
  logic        s_stb_o;
  logic        s_we_o;
  logic [31:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic        s_adr_err_i;
  logic [2:0]  grant_o;

  // Arbiter view: takes master requests and switch responses.
  modport slave (
    input  m0_stb_i, m1_stb_i, m2_stb_i, m0_we_i, m1_we_i, m2_we_i,
    input  m0_adr_i, m1_adr_i, m2_adr_i, m0_dat_i, m1_dat_i, m2_dat_i,
    input  m0_sel_i, m1_sel_i, m2_sel_i,
    output m0_dat_o, m1_dat_o, m2_dat_o, m0_ack_o, m1_ack_o, m2_ack_o,
    output m0_err_o, m1_err_o, m2_err_o,
    output s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    input  s_dat_i, s_ack_i, s_adr_err_i,
    output grant_o
  );

  // Environment view: masters plus the switch.
  modport master (
    output m0_stb_i, m1_stb_i, m2_stb_i, m0_we_i, m1_we_i, m2_we_i,
    output m0_adr_i, m1_adr_i, m2_adr_i, m0_dat_i, m1_dat_i, m2_dat_i,
    output m0_sel_i, m1_sel_i, m2_sel_i,
    input  m0_dat_o, m1_dat_o, m2_dat_o, m0_ack_o, m1_ack_o, m2_ack_o,
    input  m0_err_o, m1_err_o, m2_err_o,
    input  s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
    output s_dat_i, s_ack_i, s_adr_err_i,
    input  grant_o
  );
endinterface

// File: rtl/bus_arbiter_per.sv
// Three-master round-robin arbiter for the peripheral bus switch, with a per-transaction
// watchdog and address-error passthrough as master error terminations.
module bus_arbiter_per #(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bus_arbiter_per_if.slave   bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

  logic [0:0]      state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [1:0]      last_q, last_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic [2:0]  stb_c, we_c;
  logic [31:0] adr_c [3];
  logic [31:0] dat_c [3];
  logic [3:0]  sel_c [3];

  assign stb_c    = {bus.m2_stb_i, bus.m1_stb_i, bus.m0_stb_i};
  assign we_c     = {bus.m2_we_i, bus.m1_we_i, bus.m0_we_i};
  assign adr_c[0] = bus.m0_adr_i;
  assign adr_c[1] = bus.m1_adr_i;
  assign adr_c[2] = bus.m2_adr_i;
  assign dat_c[0] = bus.m0_dat_i;
  assign dat_c[1] = bus.m1_dat_i;
  assign dat_c[2] = bus.m2_dat_i;
  assign sel_c[0] = bus.m0_sel_i;
  assign sel_c[1] = bus.m1_sel_i;
  assign sel_c[2] = bus.m2_sel_i;

  // Reset gates every combinational output so a reset mid-transfer never terminates it.
  logic busy_c, gstb_c, timeout_c, ack_hit_c, err_hit_c;
  assign busy_c    = (state_q == BUSY) && !rst_i;
  assign gstb_c    = |(grant_q & stb_c);
  assign timeout_c = (cnt_q == CNT_LAST);
  assign ack_hit_c = busy_c && gstb_c && bus.s_ack_i;
  assign err_hit_c = busy_c && gstb_c && !bus.s_ack_i && (bus.s_adr_err_i || timeout_c);

  // Rotating search starting just after the last granted master.
  logic [1:0] pick_c;
  logic       found_c;
  always_comb begin : arb
    logic [1:0] idx;
    pick_c  = 2'd0;
    found_c = 1'b0;
    idx     = last_q;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!found_c && stb_c[idx]) begin
        found_c = 1'b1;
        pick_c  = idx;
      end
    end
  end

  // One-hot AND-OR mux of the granted master onto the switch port.
  logic        we_m;
  logic [31:0] adr_m, dat_m;
  logic [3:0]  sel_m;
  always_comb begin
    we_m  = 1'b0;
    adr_m = '0;
    dat_m = '0;
    sel_m = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant_q[i]) begin
        we_m  = we_m | we_c[i];
        adr_m = adr_m | adr_c[i];
        dat_m = dat_m | dat_c[i];
        sel_m = sel_m | sel_c[i];
      end
    end
  end

  assign bus.s_stb_o = busy_c && gstb_c;
  assign bus.s_we_o  = busy_c && we_m;
  assign bus.s_adr_o = busy_c ? adr_m : '0;
  assign bus.s_dat_o = busy_c ? dat_m : '0;
  assign bus.s_sel_o = busy_c ? sel_m : '0;

  assign bus.m0_ack_o = ack_hit_c && grant_q[0];
  assign bus.m1_ack_o = ack_hit_c && grant_q[1];
  assign bus.m2_ack_o = ack_hit_c && grant_q[2];
  assign bus.m0_err_o = err_hit_c && grant_q[0];
  assign bus.m1_err_o = err_hit_c && grant_q[1];
  assign bus.m2_err_o = err_hit_c && grant_q[2];

  assign bus.m0_dat_o = bus.s_dat_i;
  assign bus.m1_dat_o = bus.s_dat_i;
  assign bus.m2_dat_o = bus.s_dat_i;
  assign bus.grant_o  = grant_q & {3{!rst_i}};

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = BUSY;
          grant_d = 3'b001 << pick_c;
          last_d  = pick_c;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (!gstb_c || bus.s_ack_i || bus.s_adr_err_i || timeout_c) begin
          state_d = IDLE;
          grant_d = 3'b000;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      last_q  <= 2'd2;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_per.sv
// Directed, table-driven bench for bus_arbiter_per with TIMEOUT=4.
module tb_bus_arbiter_per;

  localparam int unsigned TO_W    = 8;
  localparam int unsigned TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;

  bus_arbiter_per_if bus ();

  bus_arbiter_per #(.TO_W(TO_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] stb;
    logic       ack;
    logic       aerr;
    logic [2:0] grant;
    logic [2:0] mack;
    logic [2:0] merr;
    logic       sstb;
  } vec_t;

  vec_t        vecs[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_adr [3];
  logic [31:0] m_dat [3];
  logic [3:0]  m_sel [3];
  logic [2:0]  m_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] stb, input logic ack,
                       input logic aerr, input logic [31:0] dat);
    rst             = r;
    bus.m0_stb_i    = stb[0];
    bus.m1_stb_i    = stb[1];
    bus.m2_stb_i    = stb[2];
    bus.s_ack_i     = ack;
    bus.s_adr_err_i = aerr;
    bus.s_dat_i     = dat;
  endtask

  task automatic add(input logic r, input logic [2:0] stb, input logic ack, input logic aerr,
                     input logic [2:0] grant, input logic [2:0] mack, input logic [2:0] merr,
                     input logic sstb);
    vec_t v;
    v.rst = r; v.stb = stb; v.ack = ack; v.aerr = aerr;
    v.grant = grant; v.mack = mack; v.merr = merr; v.sstb = sstb;
    vecs.push_back(v);
  endtask

  task automatic check_row(input string tag, input vec_t v, input logic [31:0] dat);
    logic [31:0] ea, ed;
    logic [3:0]  es;
    logic        ew;
    ea = '0; ed = '0; es = '0; ew = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (v.grant[i]) begin
        ea = ea | m_adr[i];
        ed = ed | m_dat[i];
        es = es | m_sel[i];
        ew = ew | m_we[i];
      end
    end
    chk({tag, "_grant"}, 32'(bus.grant_o), 32'(v.grant));
    chk({tag, "_s_stb"}, 32'(bus.s_stb_o), 32'(v.sstb));
    chk({tag, "_ack"}, 32'({bus.m2_ack_o, bus.m1_ack_o, bus.m0_ack_o}), 32'(v.mack));
    chk({tag, "_err"}, 32'({bus.m2_err_o, bus.m1_err_o, bus.m0_err_o}), 32'(v.merr));
    chk({tag, "_s_adr"}, bus.s_adr_o, ea);
    chk({tag, "_s_dat"}, bus.s_dat_o, ed);
    chk({tag, "_s_sel"}, 32'(bus.s_sel_o), 32'(es));
    chk({tag, "_s_we"}, 32'(bus.s_we_o), 32'(ew));
    chk({tag, "_m0_dat"}, bus.m0_dat_o, dat);
    chk({tag, "_m1_dat"}, bus.m1_dat_o, dat);
    chk({tag, "_m2_dat"}, bus.m2_dat_o, dat);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int          busy_n, acks;
    logic        err_seen, ack_seen;
    logic [31:0] dat;

    m_adr[0] = 32'h0000_0100; m_dat[0] = 32'hA0A0_A0A0; m_sel[0] = 4'hF;
    m_adr[1] = 32'h0000_1000; m_dat[1] = 32'hB1B1_B1B1; m_sel[1] = 4'h3;
    m_adr[2] = 32'h0000_2000; m_dat[2] = 32'hC2C2_C2C2; m_sel[2] = 4'hC;
    m_we     = 3'b100;
    bus.m0_we_i = m_we[0]; bus.m0_adr_i = m_adr[0]; bus.m0_dat_i = m_dat[0]; bus.m0_sel_i = m_sel[0];
    bus.m1_we_i = m_we[1]; bus.m1_adr_i = m_adr[1]; bus.m1_dat_i = m_dat[1]; bus.m1_sel_i = m_sel[1];
    bus.m2_we_i = m_we[2]; bus.m2_adr_i = m_adr[2]; bus.m2_dat_i = m_dat[2]; bus.m2_sel_i = m_sel[2];

    drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    //  rst  stb     ack   aerr  grant   mack    merr    sstb
    add(1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0); // reset
    add(1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0); // m1 request seen
    add(1'b0, 3'b010, 1'b1, 1'b0, 3'b010, 3'b010, 3'b000, 1'b1); // zero-wait ack
    add(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(1'b1, 3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0); // reset restores m0 priority
    add(1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b111, 1'b1, 1'b0, 3'b001, 3'b001, 3'b000, 1'b1);
    add(1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b111, 1'b1, 1'b0, 3'b010, 3'b010, 3'b000, 1'b1);
    add(1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b111, 1'b1, 1'b0, 3'b100, 3'b100, 3'b000, 1'b1);
    add(1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b111, 1'b1, 1'b0, 3'b001, 3'b001, 3'b000, 1'b1);
    add(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b100, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0); // m2 write, no ack
    add(1'b0, 3'b100, 1'b0, 1'b0, 3'b100, 3'b000, 3'b000, 1'b1);
    add(1'b0, 3'b100, 1'b0, 1'b0, 3'b100, 3'b000, 3'b000, 1'b1);
    add(1'b0, 3'b100, 1'b0, 1'b0, 3'b100, 3'b000, 3'b000, 1'b1);
    add(1'b0, 3'b100, 1'b0, 1'b0, 3'b100, 3'b000, 3'b100, 1'b1); // timeout on 4th busy cycle
    add(1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b111, 1'b0, 1'b1, 3'b001, 3'b000, 3'b001, 1'b1); // m0 wins, address error
    add(1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b010, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1);
    add(1'b0, 3'b010, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1);
    add(1'b0, 3'b010, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1);
    add(1'b0, 3'b010, 1'b1, 1'b1, 3'b010, 3'b010, 3'b000, 1'b1); // ack beats timeout and adr err
    add(1'b0, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b001, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, 1'b1);
    add(1'b0, 3'b000, 1'b1, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0); // abandon beats ack
    add(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b100, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(1'b1, 3'b100, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0); // reset mid-busy
    add(1'b0, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    add(1'b0, 3'b111, 1'b1, 1'b0, 3'b001, 3'b001, 3'b000, 1'b1);
    add(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);

    foreach (vecs[i]) begin
      dat = (i == 2) ? 32'hDEAD_BEEF : {16'h5A5A, 16'(i)};
      drive(vecs[i].rst, vecs[i].stb, vecs[i].ack, vecs[i].aerr, dat);
      @(negedge clk);
      check_row($sformatf("row%0d", i), vecs[i], dat);
      @(posedge clk);
      #1;
    end

    // Watchdog: count busy cycles up to the error, bounded.
    drive(1'b0, 3'b100, 1'b0, 1'b0, 32'h0);
    busy_n = 0; err_seen = 1'b0; ack_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.grant_o == 3'b100) busy_n++;
      if (bus.m2_ack_o) ack_seen = 1'b1;
      if (bus.m2_err_o) begin
        err_seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("wd_err_seen", 32'(err_seen), 32'd1);
    chk("wd_busy_cycles", 32'(busy_n), 32'(TIMEOUT));
    chk("wd_no_ack", 32'(ack_seen), 32'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("wd_idle_grant", 32'(bus.grant_o), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back: m0 holding stb with a zero-wait slave gets one ack every other cycle.
    drive(1'b0, 3'b001, 1'b1, 1'b0, 32'h1234_5678);
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.m0_ack_o) acks++;
      chk($sformatf("b2b_grant%0d", k), 32'(bus.grant_o), (k % 2 == 1) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end
    chk("b2b_acks", 32'(acks), 32'd4);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
